video_timing_rx: RTL and testbench

VIDEO_TIMING_RX -- requirements
Module: video_timing_rx

---
 rtl/video_rx_pkg.sv | 16 +
 rtl/sync_edge_det.sv | 29 ++
 rtl/video_timing_rx.sv | 151 +++++++++++++++
 tb/tb_video_timing_rx.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/video_rx_pkg.sv
// video_rx_pkg: FSM state encoding, err_flags bit positions and pixel width
// shared by the video timing receiver.
package video_rx_pkg;

  typedef enum logic {
    S_WAIT  = 1'b0,
    S_FRAME = 1'b1
  } rx_state_e;

  localparam int ERR_HCOUNT = 0;
  localparam int ERR_VCOUNT = 1;
  localparam int ERR_SYNC   = 2;

  localparam int RGB_W = 24;

endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: single register stage on a video control input, with rise
// and fall pulses taken against the previous registered sample.
module sync_edge_det #(
  parameter logic IDLE = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      q    <= IDLE;
      prev <= IDLE;
    end else begin
      q    <= d;
      prev <= q;
    end
  end

  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/video_timing_rx.sv
// video_timing_rx: captures active pixels and checks line/frame geometry.
// Optional per-frame pixel checksum output is enabled by VIDEO_RX_CHECKSUM_EN.
//
// state   | meaning
// S_WAIT  | idle until the first vid_vs falling edge
// S_FRAME | capturing pixels and checking line/frame geometry
module video_timing_rx
  import video_rx_pkg::*;
#(
  parameter int HDISP = 800,
  parameter int VDISP = 480
) (
  input  logic                     pixel_clk,
  input  logic                     pixel_rst,
  input  logic                     vid_hs,
  input  logic                     vid_vs,
  input  logic                     vid_blank,
  input  logic [RGB_W-1:0]         vid_rgb,
  output logic                     pix_valid,
  output logic [$clog2(HDISP)-1:0] pix_x,
  output logic [$clog2(VDISP)-1:0] pix_y,
  output logic [RGB_W-1:0]         pix_rgb,
  output logic                     frame_done,
  output logic                     frame_ok,
  output logic [2:0]               err_flags,
  output logic [15:0]              frame_cnt
`ifdef VIDEO_RX_CHECKSUM_EN
  ,
  output logic [31:0]              frame_sum
`endif
);

  localparam int XW = $clog2(HDISP);
  localparam int YW = $clog2(VDISP);
  localparam int CW = 16;
  localparam logic [CW-1:0] H_END   = CW'(HDISP);
  localparam logic [CW-1:0] V_END   = CW'(VDISP);
  localparam logic [CW-1:0] CNT_MAX = '1;

  logic hs_q, hs_rise, hs_fall;
  logic vs_q, vs_rise, vs_fall;
  logic blank_q, blank_rise, blank_fall;
  logic [RGB_W-1:0] rgb_q;

  sync_edge_det #(.IDLE(1'b1)) u_hs (
    .clk(pixel_clk), .rst(pixel_rst), .d(vid_hs),
    .q(hs_q), .rise(hs_rise), .fall(hs_fall)
  );
  sync_edge_det #(.IDLE(1'b1)) u_vs (
    .clk(pixel_clk), .rst(pixel_rst), .d(vid_vs),
    .q(vs_q), .rise(vs_rise), .fall(vs_fall)
  );
  sync_edge_det #(.IDLE(1'b0)) u_blank (
    .clk(pixel_clk), .rst(pixel_rst), .d(vid_blank),
    .q(blank_q), .rise(blank_rise), .fall(blank_fall)
  );

  logic unused_edges;
  assign unused_edges = hs_rise | hs_fall | vs_rise | blank_rise;

  always_ff @(posedge pixel_clk) begin
    if (pixel_rst) rgb_q <= '0;
    else           rgb_q <= vid_rgb;
  end

  rx_state_e     state;
  logic [CW-1:0] col, row, closed;
  logic          in_frame, active, line_end, frame_end, capture;
  logic [2:0]    err_set, err_next;

  // A line closing in the same cycle as vid_vs falls still counts toward the frame.
  always_comb begin
    in_frame  = (state == S_FRAME);
    active    = in_frame & blank_q;
    line_end  = in_frame & blank_fall;
    frame_end = in_frame & vs_fall;
    capture   = active & (col < H_END) & (row < V_END);
    closed    = row + CW'(line_end);
    err_set   = '0;
    err_set[ERR_HCOUNT] = (active & (col >= H_END)) | (line_end & (col != H_END));
    err_set[ERR_VCOUNT] = (active & (row >= V_END)) | (frame_end & (closed != V_END));
    err_set[ERR_SYNC]   = active & (~hs_q | ~vs_q);
    err_next  = (frame_done ? 3'b000 : err_flags) | err_set;
  end

  always_ff @(posedge pixel_clk) begin
    if (pixel_rst) begin
      state      <= S_WAIT;
      col        <= '0;
      row        <= '0;
      pix_valid  <= 1'b0;
      pix_x      <= '0;
      pix_y      <= '0;
      pix_rgb    <= '0;
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
      err_flags  <= '0;
      frame_cnt  <= '0;
    end else begin
      pix_valid  <= capture;
      frame_done <= frame_end;
      if (capture) begin
        pix_x   <= col[XW-1:0];
        pix_y   <= row[YW-1:0];
        pix_rgb <= rgb_q;
      end
      case (state)
        S_WAIT: begin
          if (vs_fall) begin
            state <= S_FRAME;
            col   <= '0;
            row   <= '0;
          end
        end
        S_FRAME: begin
          err_flags <= err_next;
          if (frame_end) begin
            col       <= '0;
            row       <= '0;
            frame_ok  <= (err_next == 3'b000);
            frame_cnt <= frame_cnt + 16'd1;
          end else if (line_end) begin
            col <= '0;
            if (row != CNT_MAX) row <= row + CW'(1);
          end else if (active && col != CNT_MAX) begin
            col <= col + CW'(1);
          end
        end
        default: state <= S_WAIT;
      endcase
    end
  end

`ifdef VIDEO_RX_CHECKSUM_EN
  logic [31:0] sum_acc, sum_add;
  assign sum_add = capture ? {{(32-RGB_W){1'b0}}, rgb_q} : 32'd0;

  always_ff @(posedge pixel_clk) begin
    if (pixel_rst) begin
      sum_acc   <= '0;
      frame_sum <= '0;
    end else if (frame_end) begin
      frame_sum <= sum_acc + sum_add;
      sum_acc   <= '0;
    end else begin
      sum_acc   <= sum_acc + sum_add;
    end
  end
`endif

endmodule

// File: tb/tb_video_timing_rx.sv
// tb_video_timing_rx: directed frames; expected pixels and frame verdicts are
// queued as stimulus is driven and popped when the receiver produces them.
module tb_video_timing_rx;

  localparam int HDISP = 160;
  localparam int VDISP = 90;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        pixel_rst, vid_hs, vid_vs, vid_blank;
  logic [23:0] vid_rgb;
  logic        pix_valid;
  logic [7:0]  pix_x;
  logic [6:0]  pix_y;
  logic [23:0] pix_rgb;
  logic        frame_done, frame_ok;
  logic [2:0]  err_flags;
  logic [15:0] frame_cnt;
`ifdef VIDEO_RX_CHECKSUM_EN
  logic [31:0] frame_sum;
`endif

  video_timing_rx #(.HDISP(HDISP), .VDISP(VDISP)) dut (
    .pixel_clk (clk),
    .pixel_rst (pixel_rst),
    .vid_hs    (vid_hs),
    .vid_vs    (vid_vs),
    .vid_blank (vid_blank),
    .vid_rgb   (vid_rgb),
    .pix_valid (pix_valid),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pix_rgb   (pix_rgb),
    .frame_done(frame_done),
    .frame_ok  (frame_ok),
    .err_flags (err_flags),
    .frame_cnt (frame_cnt)
`ifdef VIDEO_RX_CHECKSUM_EN
    ,
    .frame_sum (frame_sum)
`endif
  );

  typedef struct {
    int          due;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [23:0] rgb;
  } pix_t;

  typedef struct {
    int          due;
    logic        ok;
    logic [2:0]  err;
    logic [15:0] cnt;
    logic [31:0] sum;
  } frm_t;

  pix_t pq[$];
  frm_t fq[$];
  pix_t p;
  frm_t f;

  int   ncyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   started = 1'b0;
  logic fd_prev = 1'b0;

  // reference model of the receiver's frame bookkeeping
  bit          armed, line_open, vs_prev;
  int          px, py, fcnt;
  logic [2:0]  merr;
  logic [31:0] msum;

  always @(posedge clk) ncyc <= ncyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pix_valid"},  64'(pix_valid),  64'd0);
    check({tag, "_pix_x"},      64'(pix_x),      64'd0);
    check({tag, "_pix_y"},      64'(pix_y),      64'd0);
    check({tag, "_pix_rgb"},    64'(pix_rgb),    64'd0);
    check({tag, "_frame_done"}, 64'(frame_done), 64'd0);
    check({tag, "_frame_ok"},   64'(frame_ok),   64'd0);
    check({tag, "_err_flags"},  64'(err_flags),  64'd0);
    check({tag, "_frame_cnt"},  64'(frame_cnt),  64'd0);
`ifdef VIDEO_RX_CHECKSUM_EN
    check({tag, "_frame_sum"},  64'(frame_sum),  64'd0);
`endif
  endtask

  task automatic drive(input logic hs, input logic vs, input logic blank, input logic [23:0] rgb);
    @(negedge clk);
    vid_hs = hs; vid_vs = vs; vid_blank = blank; vid_rgb = rgb;
    if (armed) begin
      if (!blank && line_open) begin
        if (px != HDISP) merr[0] = 1'b1;
        py++;
        px = 0;
        line_open = 1'b0;
      end
      if (blank) begin
        line_open = 1'b1;
        if (px >= HDISP) merr[0] = 1'b1;
        if (py >= VDISP) merr[1] = 1'b1;
        if (!hs || !vs)  merr[2] = 1'b1;
        if (px < HDISP && py < VDISP) begin
          pq.push_back('{ncyc + 2, px[7:0], py[6:0], rgb});
          msum += {8'd0, rgb};
        end
        px++;
      end
      if (!vs && vs_prev) begin
        if (py != VDISP) merr[1] = 1'b1;
        fcnt++;
        fq.push_back('{ncyc + 2, (merr == 3'b000), merr, fcnt[15:0], msum});
        merr = '0; msum = '0; px = 0; py = 0; line_open = 1'b0;
      end
    end else if (!vs && vs_prev) begin
      armed = 1'b1;
      merr = '0; msum = '0; px = 0; py = 0; line_open = 1'b0;
    end
    vs_prev = vs;
  endtask

  task automatic send_line(input int npix, input int glitch_at, input bit const_rgb);
    logic [23:0] rgb;
    drive(1'b0, 1'b1, 1'b0, 24'h0);
    for (int i = 0; i < npix; i++) begin
      rgb = const_rgb ? 24'h000001 : 24'($urandom());
      drive((i == glitch_at) ? 1'b0 : 1'b1, 1'b1, 1'b1, rgb);
    end
  endtask

  task automatic vsync();
    drive(1'b1, 1'b0, 1'b0, 24'h0);
  endtask

  task automatic send_frame(input int nlines, input int short_line, input int glitch_line, input bit const_rgb);
    for (int l = 0; l < nlines; l++)
      send_line((l == short_line) ? HDISP - 1 : HDISP, (l == glitch_line) ? 50 : -1, const_rgb);
    vsync();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b1, 1'b0, 24'h0);
  endtask

  task automatic pulse_reset_mid();
    @(negedge clk);
    pixel_rst = 1'b1;
    vid_hs = 1'b1; vid_vs = 1'b1; vid_blank = 1'b1; vid_rgb = 24'h00ABCD;
    while (pq.size() > 0 && pq[$].due > ncyc) void'(pq.pop_back());
    armed = 1'b0; vs_prev = 1'b1; line_open = 1'b0;
    merr = '0; msum = '0; px = 0; py = 0;
    @(negedge clk);
    pixel_rst = 1'b0;
    check_reset_outputs("midrst");
  endtask

  always @(negedge clk) begin
    if (started) begin
      if (pq.size() > 0 && pq[0].due == ncyc) begin
        p = pq.pop_front();
        check("pix_valid", 64'(pix_valid), 64'd1);
        check("pix_x_y_rgb", 64'({pix_x, pix_y, pix_rgb}), 64'({p.x, p.y, p.rgb}));
      end else begin
        check("pix_idle", 64'(pix_valid), 64'd0);
      end
      if (fq.size() > 0 && fq[0].due == ncyc) begin
        f = fq.pop_front();
        check("frame_done", 64'(frame_done), 64'd1);
        check("frame_ok",   64'(frame_ok),   64'(f.ok));
        check("err_flags",  64'(err_flags),  64'(f.err));
        check("frame_cnt",  64'(frame_cnt),  64'(f.cnt));
`ifdef VIDEO_RX_CHECKSUM_EN
        check("frame_sum",  64'(frame_sum),  64'(f.sum));
`endif
      end else begin
        check("frame_done_idle", 64'(frame_done), 64'd0);
      end
      if (fd_prev) check("err_clear", 64'(err_flags), 64'd0);
      fd_prev = frame_done;
    end
  end

  initial begin
    pixel_rst = 1'b1;
    vid_hs = 1'b1; vid_vs = 1'b1; vid_blank = 1'b0; vid_rgb = 24'h0;
    armed = 1'b0; line_open = 1'b0; vs_prev = 1'b1;
    px = 0; py = 0; fcnt = 0; merr = '0; msum = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    pixel_rst = 1'b0;
    started = 1'b1;

    // pixels before the first vid_vs falling edge are ignored
    idle(3);
    send_line(HDISP, -1, 1'b0);
    vsync();

    send_frame(VDISP, -1, -1, 1'b0);
    send_frame(VDISP, -1, -1, 1'b0);
    send_frame(VDISP, -1, -1, 1'b1);
    idle(3);
    check("frame_cnt_after_3", 64'(frame_cnt), 64'd3);
`ifdef VIDEO_RX_CHECKSUM_EN
    check("frame_sum_const", 64'(frame_sum), 64'd14400);
`endif

    // short line 10, hs glitch on line 20, and a 91st line
    send_frame(VDISP + 1, 10, 20, 1'b0);
    send_frame(VDISP, -1, -1, 1'b0);

    // reset at line 45 of a discarded frame
    for (int l = 0; l < 45; l++) send_line(4, -1, 1'b0);
    send_line(2, -1, 1'b0);
    pulse_reset_mid();
    drive(1'b1, 1'b1, 1'b1, 24'h123456);
    drive(1'b1, 1'b1, 1'b1, 24'h654321);
    for (int l = 0; l < 3; l++) send_line(4, -1, 1'b0);
    vsync();
    send_line(HDISP, -1, 1'b0);
    send_line(HDISP, -1, 1'b0);
    idle(4);

    check("frame_cnt_after_rst", 64'(frame_cnt), 64'd0);
    check("pix_queue_drained",   64'(pq.size()), 64'd0);
    check("frame_queue_drained", 64'(fq.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
